// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter,
// registered rise/fall pulses, mode-qualified event and software-cleared sticky flag.
module multi_edge_detector #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     pos,
  output logic [WIDTH-1:0]     neg,
  output logic [WIDTH-1:0]     evt,
  output logic [WIDTH-1:0]     sticky,
  output logic                 any
);

  localparam int unsigned DEB_EFF = (DEBOUNCE == 0) ? 1 : DEBOUNCE;
  localparam int unsigned CNT_W   = $clog2(DEB_EFF) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_EFF - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_state;
  logic [WIDTH-1:0][CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]                  r_pos;
  logic [WIDTH-1:0]                  r_neg;
  logic [WIDTH-1:0]                  r_sticky;

  logic [WIDTH-1:0]                  w_synced;
  logic [WIDTH-1:0]                  w_state_nxt;
  logic [WIDTH-1:0][CNT_W-1:0]       w_cnt_nxt;
  logic [WIDTH-1:0]                  w_pos_nxt;
  logic [WIDTH-1:0]                  w_neg_nxt;
  logic [WIDTH-1:0]                  w_evt;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Debounce: the accepted state flips only after DEB_EFF consecutive mismatches
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_pos_nxt   = '0;
    w_neg_nxt   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (w_synced[i] != r_state[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_state_nxt[i] = w_synced[i];
          w_pos_nxt[i]   = w_synced[i];
          w_neg_nxt[i]   = ~w_synced[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event qualification uses the live mode so a mode change acts in the same cycle
  always_comb begin
    w_evt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_evt[i] = (r_pos[i] & mode[2*i]) | (r_neg[i] & mode[2*i+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_state  <= '0;
      r_cnt    <= '0;
      r_pos    <= '0;
      r_neg    <= '0;
      r_sticky <= '0;
    end else begin
      r_sync[0] <= in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_pos_nxt;
      r_neg    <= w_neg_nxt;
      // Set dominates clear so an event coinciding with clr is not lost
      r_sticky <= (r_sticky & ~clr) | w_evt;
    end
  end

  assign pos    = r_pos;
  assign neg    = r_neg;
  assign evt    = w_evt;
  assign sticky = r_sticky;
  assign any    = |r_sticky;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: directed corner sequences, randomized
// traffic against a sliding-window reference model, and a vector table for a fast variant.
module tb_multi_edge_detector;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int HL = SS + DB;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     in;
  logic [2*W-1:0]   mode;
  logic [W-1:0]     clr;
  logic [W-1:0]     pos, neg, evt, sticky;
  logic             any;

  logic             rst2_n;
  logic             in2;
  logic [1:0]       mode2;
  logic             clr2;
  logic             pos2, neg2, evt2, sticky2, any2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: history of sampled inputs, accepted state, pulses, sticky
  logic [W-1:0] m_hist [HL];
  logic [W-1:0] m_state, m_pos, m_neg, m_sticky;
  int cnt_pos [W];
  int cnt_neg [W];
  int cnt_evt [W];

  typedef struct {
    logic in;
    logic pos;
    logic neg;
  } vec_t;
  vec_t tv [10];

  always #5 clk = ~clk;

  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .clr(clr),
    .pos(pos), .neg(neg), .evt(evt), .sticky(sticky), .any(any)
  );

  multi_edge_detector #(.WIDTH(1), .SYNC_STAGES(1), .DEBOUNCE(0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in(in2), .mode(mode2), .clr(clr2),
    .pos(pos2), .neg(neg2), .evt(evt2), .sticky(sticky2), .any(any2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] qual(input logic [W-1:0] p, input logic [W-1:0] n,
                                         input logic [2*W-1:0] md);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (p[i] & md[2*i]) | (n[i] & md[2*i+1]);
    return r;
  endfunction

  // A channel flips when its last DB synchronised samples all disagree with the state
  task automatic model_edge();
    logic flip;
    if (!rst_n) begin
      for (int j = 0; j < HL; j++) m_hist[j] = '0;
      m_state = '0; m_pos = '0; m_neg = '0; m_sticky = '0;
    end else begin
      m_sticky = (m_sticky & ~clr) | qual(m_pos, m_neg, mode);
      for (int c = 0; c < W; c++) begin
        flip = 1'b1;
        for (int j = SS - 1; j <= SS + DB - 2; j++)
          if (m_hist[j][c] == m_state[c]) flip = 1'b0;
        m_pos[c] = flip & ~m_state[c];
        m_neg[c] = flip & m_state[c];
        if (flip) m_state[c] = ~m_state[c];
      end
      for (int j = HL - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = in;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      cnt_pos[i] = 0; cnt_neg[i] = 0; cnt_evt[i] = 0;
    end
  endtask

  // One clock: update model at the edge, compare everything on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_pos",    32'(pos),    32'(m_pos));
    chk("model_neg",    32'(neg),    32'(m_neg));
    chk("model_evt",    32'(evt),    32'(qual(m_pos, m_neg, mode)));
    chk("model_sticky", 32'(sticky), 32'(m_sticky));
    chk("model_any",    32'(any),    32'(|m_sticky));
    for (int i = 0; i < W; i++) begin
      cnt_pos[i] += int'(pos[i]);
      cnt_neg[i] += int'(neg[i]);
      cnt_evt[i] += int'(evt[i]);
    end
  endtask

  initial begin
    int guard;
    tv[0] = '{1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b1, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b0, 1'b0};
    tv[5] = '{1'b1, 1'b0, 1'b1};
    tv[6] = '{1'b0, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b0, 1'b1};
    tv[8] = '{1'b0, 1'b0, 1'b0};
    tv[9] = '{1'b0, 1'b0, 1'b0};

    m_state = '0; m_pos = '0; m_neg = '0; m_sticky = '0;
    for (int j = 0; j < HL; j++) m_hist[j] = '0;
    clear_counts();
    rst_n = 1'b0; in = '0; mode = '0; clr = '0;
    rst2_n = 1'b0; in2 = 1'b0; mode2 = 2'b11; clr2 = 1'b0;

    // Reset held three cycles
    repeat (3) cycle();
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_neg", 32'(neg), 32'h0);
    chk("rst_evt", 32'(evt), 32'h0);
    chk("rst_sticky", 32'(sticky), 32'h0);
    chk("rst_any", 32'(any), 32'h0);

    // Latency: pulse lands after edge SS+DB and lasts one cycle
    rst_n = 1'b1; in = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      chk("lat_pos0", 32'(pos[0]), 32'(e == SS + DB));
      chk("lat_neg0", 32'(neg[0]), 32'h0);
    end

    // Glitch shorter than DB is filtered, DB-long pulse is accepted
    clear_counts();
    in[1] = 1'b1; repeat (3) cycle();
    in[1] = 1'b0; repeat (10) cycle();
    chk("glitch_pos1", 32'(cnt_pos[1]), 32'd0);
    chk("glitch_neg1", 32'(cnt_neg[1]), 32'd0);
    in[1] = 1'b1; repeat (DB) cycle();
    in[1] = 1'b0; repeat (12) cycle();
    chk("held_pos1", 32'(cnt_pos[1]), 32'd1);
    chk("held_neg1", 32'(cnt_neg[1]), 32'd1);

    // Modes off/rise/fall/both
    in = '0; repeat (10) cycle();
    clr = '1; cycle(); clr = '0;
    clear_counts();
    mode = 8'b11_10_01_00;
    in = '1; repeat (10) cycle();
    in = '0; repeat (10) cycle();
    for (int i = 0; i < W; i++) begin
      chk("mode_pos_cnt", 32'(cnt_pos[i]), 32'd1);
      chk("mode_neg_cnt", 32'(cnt_neg[i]), 32'd1);
    end
    chk("mode_evt0", 32'(cnt_evt[0]), 32'd0);
    chk("mode_evt1", 32'(cnt_evt[1]), 32'd1);
    chk("mode_evt2", 32'(cnt_evt[2]), 32'd1);
    chk("mode_evt3", 32'(cnt_evt[3]), 32'd2);
    chk("mode_sticky", 32'(sticky), 32'hE);
    chk("mode_any", 32'(any), 32'h1);

    // Sticky set, clear, and set-wins-over-clear
    clr = '1; cycle(); clr = '0;
    chk("stk_cleared", 32'(sticky), 32'h0);
    chk("stk_any0", 32'(any), 32'h0);
    mode = 8'b11_00_00_00;
    in = 4'b1000;
    guard = 0;
    while (!evt[3] && guard < 20) begin cycle(); guard++; end
    chk("stk_evt3_seen", 32'(evt[3]), 32'h1);
    chk("stk_lag", 32'(sticky[3]), 32'h0);
    cycle();
    chk("stk_set", 32'(sticky), 32'h8);
    chk("stk_any1", 32'(any), 32'h1);
    clr = 4'b1000; cycle(); clr = '0;
    chk("stk_clr", 32'(sticky), 32'h0);
    chk("stk_any_clr", 32'(any), 32'h0);
    in = '0;
    guard = 0;
    while (!evt[3] && guard < 20) begin cycle(); guard++; end
    chk("stk_evt3_fall", 32'(evt[3]), 32'h1);
    clr = 4'b1000; cycle(); clr = '0;
    chk("stk_set_wins", 32'(sticky[3]), 32'h1);
    clr = '1; cycle(); clr = '0;

    // Reset with channel 2 mid-debounce (counter at 2)
    mode = '1;
    in = 4'b0100;
    for (int e = 1; e <= 4; e++) begin
      cycle();
      chk("mid_pre_pos2", 32'(pos[2]), 32'h0);
    end
    rst_n = 1'b0; cycle();
    chk("mid_rst_pos", 32'(pos), 32'h0);
    chk("mid_rst_sticky", 32'(sticky), 32'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      chk("mid_post_pos2", 32'(pos[2]), 32'(e == SS + DB));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) in[b] = ~in[b];
      clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      if ($urandom_range(0, 19) == 0) mode = (2*W)'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1;

    // Fast variant vector table: SYNC_STAGES=1, DEBOUNCE=0
    rst2_n = 1'b0; in2 = 1'b0; cycle();
    rst2_n = 1'b1;
    for (int r = 0; r < 10; r++) begin
      in2 = tv[r].in;
      cycle();
      chk("fast_pos", 32'(pos2), 32'(tv[r].pos));
      chk("fast_neg", 32'(neg2), 32'(tv[r].neg));
      chk("fast_evt", 32'(evt2), 32'(tv[r].pos | tv[r].neg));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
